// File: rtl/address_generator.sv
// 6502-style addressing-mode decoder and effective-address generator.
// Fetches operand and indirect-pointer bytes over a ready/valid read port, then publishes ea/mode.
module address_generator #(
    parameter int ADDR_WIDTH  = 24,
    parameter int INDEX_WIDTH = 32,
    parameter int PTR_BYTES   = 2,
    parameter int ZP_WRAP     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             cc,
    input  logic [2:0]             bbb,
    input  logic [2:0]             aaa,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic [ADDR_WIDTH-1:0]  dp,
    input  logic [INDEX_WIDTH-1:0] x,
    input  logic [INDEX_WIDTH-1:0] y,
    output logic                   mem_rd,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [7:0]             mem_data,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             mode,
    output logic [ADDR_WIDTH-1:0]  ea,
    output logic [1:0]             operand_bytes
);

    localparam logic [3:0] M_NONE  = 4'd0;
    localparam logic [3:0] M_A     = 4'd1;
    localparam logic [3:0] M_IMM   = 4'd2;
    localparam logic [3:0] M_ZP    = 4'd3;
    localparam logic [3:0] M_ZP_X  = 4'd4;
    localparam logic [3:0] M_ABS   = 4'd5;
    localparam logic [3:0] M_ABS_X = 4'd6;
    localparam logic [3:0] M_ABS_Y = 4'd7;
    localparam logic [3:0] M_IND_X = 4'd8;
    localparam logic [3:0] M_IND_Y = 4'd9;
    localparam logic [3:0] M_ZP_Y  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FETCH_OP  = 2'd1,
        S_FETCH_PTR = 2'd2,
        S_COMPUTE   = 2'd3
    } state_t;

    function automatic logic [3:0] decode_mode(input logic [1:0] f_cc,
                                               input logic [2:0] f_bbb,
                                               input logic [2:0] f_aaa);
        logic [3:0] m;
        m = M_NONE;
        case (f_cc)
            2'b01: begin
                case (f_bbb)
                    3'd0:    m = M_IND_X;
                    3'd1:    m = M_ZP;
                    3'd2:    m = M_IMM;
                    3'd3:    m = M_ABS;
                    3'd4:    m = M_IND_Y;
                    3'd5:    m = M_ZP_X;
                    3'd6:    m = M_ABS_Y;
                    default: m = M_ABS_X;
                endcase
            end
            2'b00: begin
                case (f_bbb)
                    3'd0:    m = M_IMM;
                    3'd1:    m = M_ZP;
                    3'd3:    m = M_ABS;
                    3'd5:    m = (f_aaa == 3'd0) ? M_ZP : M_ZP_X;
                    3'd7:    m = (f_aaa == 3'd0 || f_aaa == 3'd4) ? M_ABS : M_ABS_X;
                    default: m = M_NONE;
                endcase
            end
            2'b10: begin
                case (f_bbb)
                    3'd0:    m = M_IMM;
                    3'd1:    m = M_ZP;
                    3'd2:    m = M_A;
                    3'd3:    m = M_ABS;
                    3'd5:    m = (f_aaa == 3'd4 || f_aaa == 3'd5) ? M_ZP_Y : M_ZP_X;
                    3'd7:    m = (f_aaa == 3'd5) ? M_ABS_Y : M_ABS_X;
                    default: m = M_NONE;
                endcase
            end
            default: begin
                case (f_bbb)
                    3'd0:    m = M_IMM;
                    3'd1:    m = M_ZP;
                    3'd3:    m = M_ABS;
                    3'd5:    m = M_ZP_X;
                    3'd7:    m = M_ABS_X;
                    default: m = M_NONE;
                endcase
            end
        endcase
        return m;
    endfunction

    function automatic logic [1:0] bytes_for(input logic [3:0] m);
        case (m)
            M_ZP, M_ZP_X, M_ZP_Y, M_IND_X, M_IND_Y: return 2'd1;
            M_ABS, M_ABS_X, M_ABS_Y:                return 2'd2;
            default:                                return 2'd0;
        endcase
    endfunction

    // Zero-page offset: wraps inside the 256-byte page unless ZP_WRAP is cleared.
    function automatic logic [ADDR_WIDTH-1:0] zp_off(input logic [7:0]             b,
                                                      input logic [INDEX_WIDTH-1:0] r);
        logic [7:0] s;
        s = b + r[7:0];
        if (ZP_WRAP != 0)
            return ADDR_WIDTH'(s);
        return ADDR_WIDTH'(b) + ADDR_WIDTH'(r);
    endfunction

    state_t                  r_state, w_state_nx;
    logic                    r_busy, w_busy_nx;
    logic                    r_done, w_done_nx;
    logic                    r_mem_rd, w_rd_nx;
    logic [ADDR_WIDTH-1:0]   r_mem_addr, w_addr_nx;
    logic [ADDR_WIDTH-1:0]   r_ea, w_ea_nx;
    logic [3:0]              r_mode, w_mode_nx;
    logic [1:0]              r_ob, w_ob_nx;
    logic [1:0]              r_cnt, w_cnt_nx;

    logic [ADDR_WIDTH-1:0]   r_pc, r_dp;
    logic [INDEX_WIDTH-1:0]  r_x, r_y;
    logic [3:0]              r_lmode;
    logic [1:0]              r_lob;
    logic [15:0]             r_opnd;
    logic [23:0]             r_ptr;

    logic [3:0]              w_dec_mode;
    logic [1:0]              w_dec_ob;
    logic                    w_xfer;
    logic [ADDR_WIDTH-1:0]   w_a16, w_ptr, w_ptr_base, w_ea_calc;

    assign w_dec_mode = decode_mode(cc, bbb, aaa);
    assign w_dec_ob   = bytes_for(w_dec_mode);
    assign w_xfer     = r_mem_rd && mem_ready;
    assign w_a16      = ADDR_WIDTH'(r_opnd);
    assign w_ptr      = ADDR_WIDTH'(r_ptr);
    // The pointer base is formed from the zero-page byte arriving on this very edge.
    assign w_ptr_base = (r_lmode == M_IND_X) ? r_dp + zp_off(mem_data, r_x)
                                             : r_dp + ADDR_WIDTH'(mem_data);

    always_comb begin
        w_ea_calc = '0;
        case (r_lmode)
            M_IMM:   w_ea_calc = r_pc;
            M_ZP:    w_ea_calc = r_dp + ADDR_WIDTH'(r_opnd[7:0]);
            M_ZP_X:  w_ea_calc = r_dp + zp_off(r_opnd[7:0], r_x);
            M_ZP_Y:  w_ea_calc = r_dp + zp_off(r_opnd[7:0], r_y);
            M_ABS:   w_ea_calc = w_a16;
            M_ABS_X: w_ea_calc = w_a16 + ADDR_WIDTH'(r_x);
            M_ABS_Y: w_ea_calc = w_a16 + ADDR_WIDTH'(r_y);
            M_IND_X: w_ea_calc = w_ptr;
            M_IND_Y: w_ea_calc = w_ptr + ADDR_WIDTH'(r_y);
            default: w_ea_calc = '0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_busy_nx  = r_busy;
        w_done_nx  = 1'b0;
        w_rd_nx    = r_mem_rd;
        w_addr_nx  = r_mem_addr;
        w_ea_nx    = r_ea;
        w_mode_nx  = r_mode;
        w_ob_nx    = r_ob;
        w_cnt_nx   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_busy_nx = 1'b1;
                    w_cnt_nx  = 2'd0;
                    if (w_dec_ob != 2'd0) begin
                        w_state_nx = S_FETCH_OP;
                        w_rd_nx    = 1'b1;
                        w_addr_nx  = pc;
                    end else begin
                        w_state_nx = S_COMPUTE;
                    end
                end
            end
            S_FETCH_OP: begin
                if (w_xfer) begin
                    if (r_cnt == r_lob - 2'd1) begin
                        w_cnt_nx = 2'd0;
                        if (r_lmode == M_IND_X || r_lmode == M_IND_Y) begin
                            w_state_nx = S_FETCH_PTR;
                            w_addr_nx  = w_ptr_base;
                        end else begin
                            w_state_nx = S_COMPUTE;
                            w_rd_nx    = 1'b0;
                        end
                    end else begin
                        w_cnt_nx  = r_cnt + 2'd1;
                        w_addr_nx = r_mem_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FETCH_PTR: begin
                if (w_xfer) begin
                    if (r_cnt == 2'(PTR_BYTES - 1)) begin
                        w_state_nx = S_COMPUTE;
                        w_rd_nx    = 1'b0;
                    end else begin
                        w_cnt_nx  = r_cnt + 2'd1;
                        w_addr_nx = r_mem_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            S_COMPUTE: begin
                w_ea_nx    = w_ea_calc;
                w_mode_nx  = r_lmode;
                w_ob_nx    = r_lob;
                w_done_nx  = 1'b1;
                w_busy_nx  = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_ea       <= '0;
            r_mode     <= M_NONE;
            r_ob       <= 2'd0;
            r_cnt      <= 2'd0;
        end else begin
            r_state    <= w_state_nx;
            r_busy     <= w_busy_nx;
            r_done     <= w_done_nx;
            r_mem_rd   <= w_rd_nx;
            r_mem_addr <= w_addr_nx;
            r_ea       <= w_ea_nx;
            r_mode     <= w_mode_nx;
            r_ob       <= w_ob_nx;
            r_cnt      <= w_cnt_nx;
        end
    end

    // Operation context and fetched bytes; only meaningful while busy, so no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            r_pc    <= pc;
            r_dp    <= dp;
            r_x     <= x;
            r_y     <= y;
            r_lmode <= w_dec_mode;
            r_lob   <= w_dec_ob;
            r_opnd  <= '0;
            r_ptr   <= '0;
        end
        if (r_state == S_FETCH_OP && w_xfer) begin
            if (r_cnt[0]) r_opnd[15:8] <= mem_data;
            else          r_opnd[7:0]  <= mem_data;
        end
        if (r_state == S_FETCH_PTR && w_xfer) begin
            case (r_cnt)
                2'd0:    r_ptr[7:0]   <= mem_data;
                2'd1:    r_ptr[15:8]  <= mem_data;
                default: r_ptr[23:16] <= mem_data;
            endcase
        end
    end

    assign mem_rd        = r_mem_rd;
    assign mem_addr      = r_mem_addr;
    assign busy          = r_busy;
    assign done          = r_done;
    assign mode          = r_mode;
    assign ea            = r_ea;
    assign operand_bytes = r_ob;

endmodule

// File: tb/tb_address_generator.sv
// Directed bench for address_generator: byte-wide memory model, read logger and
// one task per addressing scenario with hand-computed expectations.
module tb_address_generator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  cc;
    logic [2:0]  bbb;
    logic [2:0]  aaa;
    logic [23:0] pc;
    logic [23:0] dp;
    logic [31:0] x;
    logic [31:0] y;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic [3:0]  mode;
    logic [23:0] ea;
    logic [1:0]  operand_bytes;

    int n_vec;
    int n_bad;

    logic [7:0]  mem [0:4095];
    logic [23:0] rd_log [0:255];
    int          rd_total;

    // {cc, bbb, aaa, expected mode, expected operand_bytes}
    localparam logic [13:0] DEC_TBL [11] = '{
        {2'd2, 3'd2, 3'd0, 4'd1,  2'd0},
        {2'd0, 3'd2, 3'd0, 4'd0,  2'd0},
        {2'd0, 3'd5, 3'd0, 4'd3,  2'd1},
        {2'd0, 3'd5, 3'd1, 4'd4,  2'd1},
        {2'd0, 3'd7, 3'd4, 4'd5,  2'd2},
        {2'd0, 3'd7, 3'd2, 4'd6,  2'd2},
        {2'd2, 3'd7, 3'd5, 4'd7,  2'd2},
        {2'd2, 3'd7, 3'd0, 4'd6,  2'd2},
        {2'd3, 3'd5, 3'd0, 4'd4,  2'd1},
        {2'd3, 3'd6, 3'd0, 4'd0,  2'd0},
        {2'd2, 3'd0, 3'd0, 4'd2,  2'd0}
    };

    address_generator dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cc            (cc),
        .bbb           (bbb),
        .aaa           (aaa),
        .pc            (pc),
        .dp            (dp),
        .x             (x),
        .y             (y),
        .mem_rd        (mem_rd),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .busy          (busy),
        .done          (done),
        .mode          (mode),
        .ea            (ea),
        .operand_bytes (operand_bytes)
    );

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr[11:0]];

    always @(posedge clk) begin
        if (mem_rd && mem_ready) begin
            rd_log[8'(rd_total)] = mem_addr;
            rd_total = rd_total + 1;
        end
    end

    task automatic run_op(input logic [1:0] c, input logic [2:0] b, input logic [2:0] a,
                          input logic [23:0] p, input logic [23:0] d,
                          input logic [31:0] xv, input logic [31:0] yv, output int lat);
        cc = c; bbb = b; aaa = a; pc = p; dp = d; x = xv; y = yv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        int seen;
        reset = 1'b1; start = 1'b1; cc = 2'd1; bbb = 3'd2; pc = 24'h000ABC;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b expected 0", done); end
        n_vec++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL rst_mem_rd: got %b expected 0", mem_rd); end
        n_vec++; if (mem_addr !== 24'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h expected 000000", mem_addr); end
        n_vec++; if (ea !== 24'h0) begin n_bad++; $display("FAIL rst_ea: got %h expected 000000", ea); end
        n_vec++; if (mode !== 4'd0) begin n_bad++; $display("FAIL rst_mode: got %0d expected 0", mode); end
        n_vec++; if (operand_bytes !== 2'd0) begin n_bad++; $display("FAIL rst_ob: got %0d expected 0", operand_bytes); end
        start = 1'b0; reset = 1'b0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL rst_start_priority: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_imm;
        int lat, rd0;
        rd0 = rd_total;
        run_op(2'd1, 3'd2, 3'd0, 24'h001000, 24'h0, 32'h0, 32'h0, lat);
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL imm_latency: got %0d expected 1", lat); end
        n_vec++; if (mode !== 4'd2) begin n_bad++; $display("FAIL imm_mode: got %0d expected 2", mode); end
        n_vec++; if (ea !== 24'h001000) begin n_bad++; $display("FAIL imm_ea: got %h expected 001000", ea); end
        n_vec++; if (operand_bytes !== 2'd0) begin n_bad++; $display("FAIL imm_ob: got %0d expected 0", operand_bytes); end
        n_vec++; if (rd_total - rd0 !== 0) begin n_bad++; $display("FAIL imm_reads: got %0d expected 0", rd_total - rd0); end
    endtask

    task automatic test_zp_x_wrap;
        int lat;
        mem[12'h100] = 8'hF0;
        run_op(2'd1, 3'd5, 3'd0, 24'h000100, 24'h000200, 32'h20, 32'h0, lat);
        n_vec++; if (ea !== 24'h000210) begin n_bad++; $display("FAIL zpx_ea: got %h expected 000210", ea); end
        n_vec++; if (mode !== 4'd4) begin n_bad++; $display("FAIL zpx_mode: got %0d expected 4", mode); end
        n_vec++; if (operand_bytes !== 2'd1) begin n_bad++; $display("FAIL zpx_ob: got %0d expected 1", operand_bytes); end
        n_vec++; if (lat !== 2) begin n_bad++; $display("FAIL zpx_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_ind_y;
        int lat, rd0;
        mem[12'h120] = 8'h40; mem[12'h040] = 8'h00; mem[12'h041] = 8'h30;
        rd0 = rd_total;
        run_op(2'd1, 3'd4, 3'd0, 24'h000120, 24'h0, 32'h0, 32'h5, lat);
        n_vec++; if (rd_total - rd0 !== 3) begin n_bad++; $display("FAIL indy_reads: got %0d expected 3", rd_total - rd0); end
        n_vec++; if (rd_log[8'(rd0)] !== 24'h000120) begin n_bad++; $display("FAIL indy_rd0: got %h expected 000120", rd_log[8'(rd0)]); end
        n_vec++; if (rd_log[8'(rd0 + 1)] !== 24'h000040) begin n_bad++; $display("FAIL indy_rd1: got %h expected 000040", rd_log[8'(rd0 + 1)]); end
        n_vec++; if (rd_log[8'(rd0 + 2)] !== 24'h000041) begin n_bad++; $display("FAIL indy_rd2: got %h expected 000041", rd_log[8'(rd0 + 2)]); end
        n_vec++; if (ea !== 24'h003005) begin n_bad++; $display("FAIL indy_ea: got %h expected 003005", ea); end
        n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL indy_latency: got %0d expected 4", lat); end
        n_vec++; if (mode !== 4'd9) begin n_bad++; $display("FAIL indy_mode: got %0d expected 9", mode); end
    endtask

    task automatic test_ind_x;
        int lat, rd0;
        mem[12'h150] = 8'hFE; mem[12'h201] = 8'hCD; mem[12'h202] = 8'hAB;
        rd0 = rd_total;
        run_op(2'd1, 3'd0, 3'd0, 24'h000150, 24'h000200, 32'h3, 32'h0, lat);
        n_vec++; if (ea !== 24'h00ABCD) begin n_bad++; $display("FAIL indx_ea: got %h expected 00abcd", ea); end
        n_vec++; if (mode !== 4'd8) begin n_bad++; $display("FAIL indx_mode: got %0d expected 8", mode); end
        n_vec++; if (lat !== 4) begin n_bad++; $display("FAIL indx_latency: got %0d expected 4", lat); end
        n_vec++; if (rd_log[8'(rd0 + 1)] !== 24'h000201) begin n_bad++; $display("FAIL indx_ptr_addr: got %h expected 000201", rd_log[8'(rd0 + 1)]); end
    endtask

    task automatic test_zp_y;
        int lat;
        mem[12'h130] = 8'h10;
        run_op(2'd2, 3'd5, 3'd5, 24'h000130, 24'h0, 32'h7, 32'h3, lat);
        n_vec++; if (mode !== 4'd10) begin n_bad++; $display("FAIL zpy_mode: got %0d expected 10", mode); end
        n_vec++; if (ea !== 24'h000013) begin n_bad++; $display("FAIL zpy_ea: got %h expected 000013", ea); end
        run_op(2'd2, 3'd5, 3'd6, 24'h000130, 24'h000100, 32'h7, 32'h3, lat);
        n_vec++; if (mode !== 4'd4) begin n_bad++; $display("FAIL zpy_alt_mode: got %0d expected 4", mode); end
        n_vec++; if (ea !== 24'h000117) begin n_bad++; $display("FAIL zpy_alt_ea: got %h expected 000117", ea); end
    endtask

    task automatic test_abs_indexed;
        int lat;
        mem[12'h140] = 8'h34; mem[12'h141] = 8'h12;
        run_op(2'd1, 3'd7, 3'd0, 24'h000140, 24'h0, 32'h10, 32'h0, lat);
        n_vec++; if (ea !== 24'h001244) begin n_bad++; $display("FAIL absx_ea: got %h expected 001244", ea); end
        n_vec++; if (mode !== 4'd6) begin n_bad++; $display("FAIL absx_mode: got %0d expected 6", mode); end
        n_vec++; if (operand_bytes !== 2'd2) begin n_bad++; $display("FAIL absx_ob: got %0d expected 2", operand_bytes); end
        n_vec++; if (lat !== 3) begin n_bad++; $display("FAIL absx_latency: got %0d expected 3", lat); end
        run_op(2'd1, 3'd6, 3'd0, 24'h000140, 24'h0, 32'h0, 32'hFFFF0000, lat);
        n_vec++; if (ea !== 24'hFF1234) begin n_bad++; $display("FAIL absy_trunc_ea: got %h expected ff1234", ea); end
        n_vec++; if (mode !== 4'd7) begin n_bad++; $display("FAIL absy_mode: got %0d expected 7", mode); end
    endtask

    task automatic test_decode;
        int lat;
        logic [13:0] e;
        mem[12'h1F0] = 8'h00; mem[12'h1F1] = 8'h00;
        for (int i = 0; i < 11; i++) begin
            e = DEC_TBL[i];
            run_op(e[13:12], e[11:9], e[8:6], 24'h0001F0, 24'h0, 32'h0, 32'h0, lat);
            n_vec++;
            if (mode !== e[5:2]) begin
                n_bad++;
                $display("FAIL decode_mode[%0d]: got %0d expected %0d", i, mode, e[5:2]);
            end
            n_vec++;
            if (operand_bytes !== e[1:0]) begin
                n_bad++;
                $display("FAIL decode_ob[%0d]: got %0d expected %0d", i, operand_bytes, e[1:0]);
            end
        end
    endtask

    task automatic test_stall_abort;
        int seen;
        mem_ready = 1'b0;
        cc = 2'd1; bbb = 3'd3; aaa = 3'd0; pc = 24'h000160; dp = 24'h0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (mem_rd !== 1'b1 || mem_addr !== 24'h000160) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got rd=%b addr=%h expected rd=1 addr=000160", i, mem_rd, mem_addr);
            end
            n_vec++;
            if (done !== 1'b0) begin n_bad++; $display("FAIL stall_done[%0d]: got %b expected 0", i, done); end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_ready = 1'b1;
        n_vec++; if (mem_rd !== 1'b0) begin n_bad++; $display("FAIL abort_mem_rd: got %b expected 0", mem_rd); end
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses expected 0", seen); end
    endtask

    task automatic test_back_to_back;
        int lat, k, seen;
        mem[12'h170] = 8'h22;
        run_op(2'd1, 3'd1, 3'd0, 24'h000170, 24'h000300, 32'h0, 32'h0, lat);
        n_vec++; if (ea !== 24'h000322) begin n_bad++; $display("FAIL b2b_first_ea: got %h expected 000322", ea); end
        cc = 2'd1; bbb = 3'd2; pc = 24'h002222;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy: got %b expected 1", busy); end
        @(posedge clk); #1;
        n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done: got %b expected 1", done); end
        n_vec++; if (ea !== 24'h002222) begin n_bad++; $display("FAIL b2b_second_ea: got %h expected 002222", ea); end

        mem[12'h180] = 8'h78; mem[12'h181] = 8'h56;
        cc = 2'd1; bbb = 3'd3; pc = 24'h000180; dp = 24'h0;
        start = 1'b1;
        @(posedge clk); #1;
        cc = 2'd1; bbb = 3'd2; pc = 24'h003333;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        n_vec++; if (k !== 2) begin n_bad++; $display("FAIL busy_start_latency: got %0d expected 2", k); end
        n_vec++; if (ea !== 24'h005678) begin n_bad++; $display("FAIL busy_start_ea: got %h expected 005678", ea); end
        n_vec++; if (mode !== 4'd5) begin n_bad++; $display("FAIL busy_start_mode: got %0d expected 5", mode); end
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL busy_start_ignored: got %0d active cycles expected 0", seen); end
        n_vec++; if (ea !== 24'h005678) begin n_bad++; $display("FAIL result_hold_ea: got %h expected 005678", ea); end
    endtask

    initial begin
        clk = 1'b0; reset = 1'b1; start = 1'b0;
        cc = 2'd0; bbb = 3'd0; aaa = 3'd0;
        pc = 24'h0; dp = 24'h0; x = 32'h0; y = 32'h0;
        mem_ready = 1'b1;
        n_vec = 0; n_bad = 0; rd_total = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        test_reset();
        test_imm();
        test_zp_x_wrap();
        test_ind_y();
        test_ind_x();
        test_zp_y();
        test_abs_indexed();
        test_decode();
        test_stall_abort();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
